// File: rtl/iir_sequencer.sv
// Sample-level controller for a first-order IIR datapath.
// Sequences one filter step per sample and owns the coefficient banks.
module iir_sequencer #(
  parameter int W         = 16,
  parameter int FILT_LAT  = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         cfg_commit,
  input  logic         cfg_flush,
  output logic         cfg_pending,
  output logic         filt_rst,
  output logic         filt_en,
  output logic [W-1:0] filt_x,
  output logic [W-1:0] filt_a1,
  output logic [W-1:0] filt_b0,
  output logic [W-1:0] filt_b1,
  input  logic [W-1:0] filt_y
);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_COMMIT,
    S_ISSUE, S_WAIT, S_OUT
  } state_t;

  localparam int CW = 8;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_pending;
  logic           r_flush;
  logic           r_filt_rst;
  logic           r_m_valid;
  logic [W-1:0]   r_m_data;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_sh_a1, r_sh_b0, r_sh_b1;
  logic [W-1:0]   r_a1, r_b0, r_b1;
  logic           w_commit_req;
  logic           w_flush_done;
  logic           w_wait_done;
  logic           w_s_ready;
  logic           w_filt_en;

  // A commit seen this cycle already blocks input acceptance.
  assign w_commit_req = r_pending | cfg_commit;
  assign w_flush_done = (r_cnt == CW'(FLUSH_CYC - 1));
  assign w_wait_done  = (r_cnt == CW'(FILT_LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FLUSH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FLUSH:  if (w_flush_done) w_next = S_IDLE;
      S_IDLE: begin
        if (w_commit_req)  w_next = S_COMMIT;
        else if (s_valid)  w_next = S_ISSUE;
      end
      S_COMMIT: w_next = r_flush ? S_FLUSH : S_IDLE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (w_wait_done) w_next = S_OUT;
      S_OUT:    if (m_ready) w_next = S_IDLE;
      default:  w_next = S_FLUSH;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_filt_en = 1'b0;
    unique case (r_state)
      S_IDLE:  w_s_ready = ~w_commit_req;
      S_ISSUE: w_filt_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_a1 <= '0;
      r_sh_b0 <= '0;
      r_sh_b1 <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    r_sh_a1 <= cfg_wdata;
        2'd1:    r_sh_b0 <= cfg_wdata;
        2'd2:    r_sh_b1 <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // A request arriving during COMMIT stays pending for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_flush   <= 1'b0;
      r_a1      <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
    end else if (r_state == S_COMMIT) begin
      r_pending <= cfg_commit;
      r_flush   <= cfg_commit & cfg_flush;
      r_a1      <= r_sh_a1;
      r_b0      <= r_sh_b0;
      r_b1      <= r_sh_b1;
    end else if (cfg_commit) begin
      r_pending <= 1'b1;
      r_flush   <= r_flush | cfg_flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt_rst <= 1'b1;
      r_x        <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_filt_rst <= (w_next == S_FLUSH);
      if (s_valid && w_s_ready)
        r_x <= s_data;
      if (r_state == S_WAIT && w_wait_done) begin
        r_m_valid <= 1'b1;
        r_m_data  <= filt_y;
      end else if (r_state == S_OUT && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready     = w_s_ready;
  assign filt_en     = w_filt_en;
  assign filt_rst    = r_filt_rst;
  assign filt_x      = r_x;
  assign filt_a1     = r_a1;
  assign filt_b0     = r_b0;
  assign filt_b1     = r_b1;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign cfg_pending = r_pending;

endmodule

// File: tb/tb_iir_sequencer.sv
// Bench for iir_sequencer: behavioural filter around the DUT and a
// sample-level reference of y = b0*x + b1*x1 - a1*y1 in Q8.8 sign-magnitude.
module tb_iir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_flush = 1'b0;
  logic        cfg_pending;
  logic        filt_rst, filt_en;
  logic [15:0] filt_x, filt_a1, filt_b0, filt_b1;
  logic [15:0] filt_y;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  iir_sequencer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_flush(cfg_flush),
    .cfg_pending(cfg_pending),
    .filt_rst(filt_rst), .filt_en(filt_en), .filt_x(filt_x),
    .filt_a1(filt_a1), .filt_b0(filt_b0), .filt_b1(filt_b1),
    .filt_y(filt_y)
  );

  function automatic longint sm2i(logic [15:0] v);
    return v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
  endfunction

  function automatic logic [15:0] i2sm(longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    return {(v < 0 && m != 0), m[14:0]};
  endfunction

  function automatic logic [15:0] iir(logic [15:0] x, x1, y1,
                                      logic [15:0] a1, b0, b1);
    longint acc;
    acc = sm2i(b0) * sm2i(x) + sm2i(b1) * sm2i(x1)
        - sm2i(a1) * sm2i(y1);
    return i2sm(acc / 256);
  endfunction

  // Filter datapath stand-in, one-cycle latency
  logic [15:0] f_x1, f_y1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_y <= '0; f_x1 <= '0; f_y1 <= '0;
    end else if (filt_rst) begin
      filt_y <= '0; f_x1 <= '0; f_y1 <= '0;
    end else if (filt_en) begin
      filt_y <= iir(filt_x, f_x1, f_y1, filt_a1, filt_b0, filt_b1);
      f_y1   <= iir(filt_x, f_x1, f_y1, filt_a1, filt_b0, filt_b1);
      f_x1   <= filt_x;
    end
  end

  always @(posedge clk) if (filt_en) en_cnt <= en_cnt + 1;

  logic [15:0] ref_sh [3];
  logic [15:0] ref_a1 = '0, ref_b0 = '0, ref_b1 = '0;
  logic [15:0] ref_x1 = '0, ref_y1 = '0;

  task automatic ref_step(input logic [15:0] x, output logic [15:0] y);
    y = iir(x, ref_x1, ref_y1, ref_a1, ref_b0, ref_b1);
    ref_x1 = x;
    ref_y1 = y;
  endtask

  task automatic ref_commit(input bit flush);
    ref_a1 = ref_sh[0]; ref_b0 = ref_sh[1]; ref_b1 = ref_sh[2];
    if (flush) begin ref_x1 = '0; ref_y1 = '0; end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    if (a != 2'd3) ref_sh[a] = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic do_commit(input bit flush);
    int n;
    cfg_commit = 1'b1; cfg_flush = flush;
    cyc();
    cfg_commit = 1'b0; cfg_flush = 1'b0;
    ref_commit(flush);
    n = 0;
    while ((cfg_pending || !s_ready) && n < 20) begin cyc(); n++; end
  endtask

  task automatic do_sample(input logic [15:0] x, input int hold,
                           output logic [15:0] yf, output logic [15:0] yl,
                           output int lat, output bit ok);
    int n;
    ok = 1'b0; yf = '0; yl = '0; lat = 0; n = 0;
    s_valid = 1'b1; s_data = x;
    while (!s_ready && n < 50) begin cyc(); n++; end
    if (!s_ready) begin s_valid = 1'b0; return; end
    cyc();
    s_valid = 1'b0;
    while (!m_valid && lat < 50) begin cyc(); lat++; end
    if (!m_valid) return;
    yf = m_data;
    repeat (hold) cyc();
    yl = m_data;
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (2) cyc();
    checks++;
    if ({s_ready, m_valid, filt_en, filt_rst, cfg_pending} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_flags: got %b want 00010",
               {s_ready, m_valid, filt_en, filt_rst, cfg_pending});
    end
    checks++;
    if ({m_data, filt_x, filt_a1, filt_b0, filt_b1} !== 80'h0) begin
      errors++;
      $display("FAIL rst_data: got %h want 0",
               {m_data, filt_x, filt_a1, filt_b0, filt_b1});
    end
    rst = 1'b1;
    n = 0;
    while (filt_rst && n < 10) begin n++; cyc(); end
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL flush_len: got %0d want 2", n);
    end
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      errors++; $display("FAIL post_rst_hs: got %b want 10", {s_ready, m_valid});
    end
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== 48'h0) begin
      errors++;
      $display("FAIL post_rst_coef: got %h want 0", {filt_a1, filt_b0, filt_b1});
    end
  endtask

  task automatic test_coeff_path();
    logic [15:0] yf, yl, e;
    int lat, e0;
    bit ok;
    cfg_write(2'd0, 16'h80D2);
    cfg_write(2'd1, 16'h0016);
    cfg_write(2'd2, 16'h0016);
    do_commit(1'b1);
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== 48'h80D2_0016_0016) begin
      errors++;
      $display("FAIL commit_coef: got %h want 80d200160016",
               {filt_a1, filt_b0, filt_b1});
    end
    e0 = en_cnt;
    ref_step(16'h0080, e);
    do_sample(16'h0080, 0, yf, yl, lat, ok);
    checks++;
    if (!ok || yf !== 16'h000B) begin
      errors++; $display("FAIL y0: ok=%0d got %h want 000b", ok, yf);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL latency: got %0d want 2", lat);
    end
    checks++;
    if (en_cnt - e0 !== 1) begin
      errors++; $display("FAIL en_pulses: got %0d want 1", en_cnt - e0);
    end
    ref_step(16'h00B3, e);
    do_sample(16'h00B3, 0, yf, yl, lat, ok);
    checks++;
    if (!ok || yf !== 16'h0023) begin
      errors++; $display("FAIL y1: ok=%0d got %h want 0023", ok, yf);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] x, e;
    int n;
    x = 16'($urandom_range(0, 16'h0FFF));
    ref_step(x, e);
    s_valid = 1'b1; s_data = x; n = 0;
    while (!s_ready && n < 50) begin cyc(); n++; end
    cyc();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin cyc(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({m_valid, s_ready} !== 2'b10 || m_data !== e) begin
        errors++;
        $display("FAIL stall%0d: v/rdy=%b data=%h want 10 %h",
                 i, {m_valid, s_ready}, m_data, e);
      end
      cyc();
    end
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release: got %b want 10", {s_ready, m_valid});
    end
  endtask

  task automatic test_commit_in_wait();
    logic [15:0] x, e;
    int n;
    x = 16'h8000 | 16'($urandom_range(0, 16'h0FFF));
    ref_step(x, e);
    s_valid = 1'b1; s_data = x; n = 0;
    while (!s_ready && n < 50) begin cyc(); n++; end
    cyc();
    s_valid = 1'b0;
    cyc();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'h0020; cfg_commit = 1'b1;
    ref_sh[1] = 16'h0020;
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin cyc(); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cfg_pending, filt_b0} !== {1'b1, 16'h0016} || m_data !== e) begin
        errors++;
        $display("FAIL wait_commit%0d: pend=%b b0=%h y=%h want 1 0016 %h",
                 i, cfg_pending, filt_b0, m_data, e);
      end
      cyc();
    end
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    checks++;
    if ({cfg_pending, s_ready, filt_b0} !== {2'b10, 16'h0016}) begin
      errors++;
      $display("FAIL pre_commit: pend/rdy=%b b0=%h want 10 0016",
               {cfg_pending, s_ready}, filt_b0);
    end
    n = 0;
    while (cfg_pending && n < 10) begin cyc(); n++; end
    ref_commit(1'b0);
    checks++;
    if ({cfg_pending, filt_b0} !== {1'b0, 16'h0020}) begin
      errors++;
      $display("FAIL post_commit: pend=%b b0=%h want 0 0020", cfg_pending, filt_b0);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] x, e, yf, yl;
    int n, lat;
    bit ok, seen_rst;
    cfg_write(2'd3, 16'hFFFF);
    x = 16'($urandom_range(0, 16'h0FFF));
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 16'h0030;
    cfg_commit = 1'b1; s_valid = 1'b1; s_data = x;
    ref_sh[2] = 16'h0030;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL commit_wins: s_ready got %b want 0", s_ready);
    end
    cyc();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    n = 0; seen_rst = 1'b0;
    while (cfg_pending && n < 10) begin
      seen_rst |= filt_rst; cyc(); n++;
    end
    seen_rst |= filt_rst;
    ref_commit(1'b0);
    checks++;
    if ({seen_rst, filt_a1, filt_b0, filt_b1} !== {1'b0, 48'h80D2_0020_0030}) begin
      errors++;
      $display("FAIL same_cycle: rst=%b coef=%h want 0 80d200200030",
               seen_rst, {filt_a1, filt_b0, filt_b1});
    end
    ref_step(x, e);
    do_sample(x, 0, yf, yl, lat, ok);
    checks++;
    if (!ok || yf !== e) begin
      errors++; $display("FAIL after_commit_y: ok=%0d got %h want %h", ok, yf, e);
    end
  endtask

  task automatic test_random();
    logic [15:0] x, e, yf, yl;
    int lat, e0;
    bit ok;
    cfg_write(2'd0, {1'($urandom), 15'($urandom_range(0, 16'h00C0))});
    cfg_write(2'd1, {1'($urandom), 15'($urandom_range(0, 16'h00C0))});
    cfg_write(2'd2, {1'($urandom), 15'($urandom_range(0, 16'h00C0))});
    do_commit(1'b1);
    for (int i = 0; i < 20; i++) begin
      x = {1'($urandom), 15'($urandom_range(0, 16'h3FFF))};
      ref_step(x, e);
      e0 = en_cnt;
      do_sample(x, $urandom_range(0, 3), yf, yl, lat, ok);
      checks++;
      if (!ok || yf !== e || yl !== e || en_cnt - e0 !== 1) begin
        errors++;
        $display("FAIL rand%0d: ok=%0d y=%h/%h en=%0d want %h en=1",
                 i, ok, yf, yl, en_cnt - e0, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    s_valid = 1'b1; s_data = 16'h0123; n = 0;
    while (!s_ready && n < 50) begin cyc(); n++; end
    cyc();
    s_valid = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({s_ready, m_valid, filt_en, filt_rst, cfg_pending} !== 5'b00010 ||
        {m_data, filt_x, filt_a1, filt_b0, filt_b1} !== 80'h0) begin
      errors++;
      $display("FAIL mid_rst: flags=%b data=%h want 00010 0",
               {s_ready, m_valid, filt_en, filt_rst, cfg_pending},
               {m_data, filt_x, filt_a1, filt_b0, filt_b1});
    end
    #3;
    rst = 1'b1;
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (m_valid) seen++;
    end
    m_ready = 1'b0;
    checks++;
    if (seen !== 0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL dropped: m_valid cycles=%0d s_ready=%b want 0 1", seen, s_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ref_sh[0] = '0; ref_sh[1] = '0; ref_sh[2] = '0;
    test_reset();
    test_coeff_path();
    test_backpressure();
    test_commit_in_wait();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
